// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle MIPS control unit: state codes
//   (also exported on dbgState), opcode constants, ALU/PC mux encodings,
//   the trap cause and the control word passed from the decoder to the top.
//   Optional feature macro: MCTRL_IMM_ALU_EN (addi/andi/ori/slti go through
//   EXI/WBI instead of trapping).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBLW  = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_EXI   = 4'd10,
    S_WBI   = 4'd11,
    S_TRAP  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_B        = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_SEXT     = 2'b10,
    SRCB_SEXT_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_t;

  // Why the last trip into TRAP happened; selects illegal_op vs mem_err.
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  typedef struct packed {
    logic   pc_write;
    logic   pc_write_cond;
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   mem_to_reg;
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src_a;
    srcb_t  alu_src_b;
    aluop_t alu_op;
    pcsrc_t pc_source;
    logic   illegal_op;
    logic   mem_err;
  } ctrl_t;

  // States that hold a memory request until mem_ack (subject to timeout).
  function automatic logic is_mem_wait(state_t s);
    return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
  endfunction

  // Dispatch out of ID on the freshly loaded opcode.
  function automatic state_t id_next_state(logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MADDR;
      OP_RTYPE:     return S_EXR;
      OP_BEQ:       return S_BR;
      OP_J:         return S_JMP;
`ifdef MCTRL_IMM_ALU_EN
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_EXI;
`endif
      default:      return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundles the controller's datapath-facing signals.
//   master : the control FSM (reads opcode/zero/mem_ack, drives controls)
//   slave  : datapath / memory side (drives opcode/zero/mem_ack)
//   Signals:
//     opcode[5:0]  IR[31:26]        zero      ALU zero flag
//     mem_ack      memory done      PCWrite   unconditional PC load
//     PCWriteCond  PC load if zero  IorD      0=PC, 1=ALUOut address
//     MemRead      read request     MemWrite  write request
//     IRWrite      IR load          MemtoReg  0=ALUOut, 1=MDR
//     RegDst       0=rd, 1=rt       RegWrite  regfile write enable
//     ALUSrcA      0=PC, 1=A        ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//     illegal_op   1-cycle pulse    mem_err   1-cycle pulse
//     dbgState[3:0] current state code
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] dbgState;

  modport master (
    input  opcode, zero, mem_ack,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, mem_err, dbgState
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, mem_err, dbgState
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mctrl_decode
//   Combinational state -> control word decoder. Every select that a state
//   does not use is driven 0. Reset gating of write enables is applied by
//   the top, not here.
//   Optional feature macro: MCTRL_IMM_ALU_EN (EXI/WBI decode).
//   Ports:
//     i_state    current FSM state
//     i_mem_ack  memory acknowledge (gates IRWrite/PCWrite in IF)
//     i_cause    trap cause, selects illegal_op or mem_err in TRAP
//     o_ctrl     decoded control word
// ---------------------------------------------------------------------------
module mctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ack,
  input  cause_t i_cause,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_IF: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // PC+4 and the IR only load once the fetch actually completes.
        o_ctrl.ir_write  = i_mem_ack;
        o_ctrl.pc_write  = i_mem_ack;
      end
      S_ID: begin
        o_ctrl.alu_src_b = SRCB_SEXT_SH2;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SEXT;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_WBLW: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_WBR: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BR: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MCTRL_IMM_ALU_EN
      S_EXI: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_SEXT;
        o_ctrl.alu_op    = ALU_IMM;
      end
      S_WBI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
`endif
      S_TRAP: begin
        o_ctrl.illegal_op = (i_cause == CAUSE_ILLEGAL);
        o_ctrl.mem_err    = (i_cause == CAUSE_TIMEOUT);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle MIPS control FSM: sequences fetch, decode, execute, memory
//   and writeback one instruction at a time. Memory requests are held until
//   mem_ack and abandoned into TRAP after MEM_TIMEOUT unacknowledged cycles
//   (MEM_TIMEOUT = 0 waits forever).
//   Optional feature macro: MCTRL_IMM_ALU_EN (addi/andi/ori/slti executed
//   via EXI/WBI; otherwise they trap as illegal).
//   Parameters:
//     MEM_TIMEOUT  max wait cycles for mem_ack in IF/MRD/MWR (0 = none)
//     CNT_W        wait-counter width, must hold MEM_TIMEOUT
//   Ports:
//     clk   system clock, all state updates on posedge
//     rst   synchronous active-low reset
//     bus   controller side of multicycle_ctrl_if (see interface header)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_wait_cnt;
  cause_t            r_cause;
  cause_t            w_cause_next;
  logic              w_timeout;
  ctrl_t             w_ctrl;

  // Timeout fires on the last permitted wait cycle; a same-cycle ack wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && is_mem_wait(r_state) && !bus.mem_ack &&
                     (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next       = S_IF;
    w_cause_next = r_cause;
    case (r_state)
      S_IF:    w_next = bus.mem_ack ? S_ID : S_IF;
      S_ID: begin
        w_next = id_next_state(bus.opcode);
        if (w_next == S_TRAP) w_cause_next = CAUSE_ILLEGAL;
      end
      S_MADDR: w_next = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   w_next = bus.mem_ack ? S_WBLW : S_MRD;
      S_WBLW:  w_next = S_IF;
      S_MWR:   w_next = bus.mem_ack ? S_IF : S_MWR;
      S_EXR:   w_next = S_WBR;
      S_WBR:   w_next = S_IF;
      S_BR:    w_next = S_IF;
      S_JMP:   w_next = S_IF;
`ifdef MCTRL_IMM_ALU_EN
      S_EXI:   w_next = S_WBI;
      S_WBI:   w_next = S_IF;
`endif
      S_TRAP:  w_next = S_IF;
      default: w_next = S_IF;
    endcase
    if (w_timeout) begin
      w_next       = S_TRAP;
      w_cause_next = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
      r_cause    <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (is_mem_wait(r_state) && !bus.mem_ack)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  mctrl_decode u_decode (
    .i_state   (r_state),
    .i_mem_ack (bus.mem_ack),
    .i_cause   (r_cause),
    .o_ctrl    (w_ctrl)
  );

  // Write enables are suppressed for the whole reset cycle so an abandoned
  // instruction cannot commit anything; selects stay Moore-decoded.
  assign bus.PCWrite     = w_ctrl.pc_write      & rst;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond & rst;
  assign bus.MemWrite    = w_ctrl.mem_write     & rst;
  assign bus.IRWrite     = w_ctrl.ir_write      & rst;
  assign bus.RegWrite    = w_ctrl.reg_write     & rst;
  assign bus.IorD        = w_ctrl.iord;
  assign bus.MemRead     = w_ctrl.mem_read;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.illegal_op  = w_ctrl.illegal_op;
  assign bus.mem_err     = w_ctrl.mem_err;
  assign bus.dbgState    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4, CNT_W=3).
//   A cycle-level reference model of the instruction sequencing predicts
//   every output at each negedge; directed sequences pin the model with
//   literal expectations, then randomized traffic exercises everything.
//   Honours MCTRL_IMM_ALU_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TO = 4;
`ifdef MCTRL_IMM_ALU_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State numbers are the architectural dbgState codes.
  int m_state    = 0;
  int m_waited   = 0;   // unacknowledged cycles spent in the current request
  bit m_cause_to = 1'b0;
  bit m_valid    = 1'b0;

  function automatic int id_target(logic [5:0] op);
    case (op)
      6'h23, 6'h2B:               return 2;
      6'h00:                      return 6;
      6'h04:                      return 8;
      6'h02:                      return 9;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return IMM_EN ? 10 : 12;
      default:                    return 12;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int nxt;
    bit to;
    if (!rst) begin
      m_state    <= 0;
      m_waited   <= 0;
      m_cause_to <= 1'b0;
      m_valid    <= 1'b1;
    end else if (m_valid) begin
      to  = 1'b0;
      nxt = 0;
      case (m_state)
        0:  nxt = bus.mem_ack ? 1 : 0;
        1:  nxt = id_target(bus.opcode);
        2:  nxt = (bus.opcode == 6'h23) ? 3 : 5;
        3:  nxt = bus.mem_ack ? 4 : 3;
        5:  nxt = bus.mem_ack ? 0 : 5;
        6:  nxt = 7;
        10: nxt = 11;
        default: nxt = 0;
      endcase
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !bus.mem_ack &&
          TO != 0 && (m_waited + 1 == TO)) begin
        nxt = 12;
        to  = 1'b1;
      end
      if (nxt == 12) m_cause_to <= to;
      m_waited <= (nxt == m_state) ? m_waited + 1 : 0;
      m_state  <= nxt;
    end
  end

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],illegal_op,mem_err,dbg[4]}
  function automatic logic [21:0] model_out(int s, bit ack, bit r, bit cause_to);
    bit pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, me;
    logic [1:0] sb, op, ps;
    pcw  = (s == 0 && ack) || s == 9;
    pcwc = (s == 8);
    iord = (s == 3 || s == 5);
    mr   = (s == 0 || s == 3);
    mw   = (s == 5);
    irw  = (s == 0 && ack);
    m2r  = (s == 4);
    rd   = (s == 4 || s == 11);
    rw   = (s == 4 || s == 7 || s == 11);
    sa   = (s == 2 || s == 6 || s == 8 || s == 10);
    sb   = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s == 2 || s == 10) ? 2'd2 : 2'd0;
    op   = (s == 8) ? 2'd1 : (s == 6) ? 2'd2 : (s == 10) ? 2'd3 : 2'd0;
    ps   = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : 2'd0;
    ill  = (s == 12) && !cause_to;
    me   = (s == 12) && cause_to;
    if (!r) begin
      pcw = 1'b0; pcwc = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
    end
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill, me, 4'(s)};
  endfunction

  logic [21:0] dut_vec;
  assign dut_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op, bus.mem_err,
                    bus.dbgState};

  always @(negedge clk) begin
    if (m_valid)
      chk("cycle_vs_model", 32'(dut_vec),
          32'(model_out(m_state, bus.mem_ack, rst, m_cause_to)));
  end

  // ---------------- stimulus ----------------
  // One clock: new inputs shortly after posedge, return at the following negedge.
  task automatic cyc(input bit r, input bit a, input bit z, input logic [5:0] op);
    @(posedge clk);
    #1;
    rst         = r;
    bus.mem_ack = a;
    bus.zero    = z;
    bus.opcode  = op;
    @(negedge clk);
  endtask

  task automatic st(input string name, input int code);
    chk(name, 32'(bus.dbgState), 32'(code));
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 9))
      0: o = 6'h00;
      1: o = 6'h23;
      2: o = 6'h2B;
      3: o = 6'h04;
      4: o = 6'h02;
      5: o = 6'h08;
      6: o = 6'h0C;
      7: o = 6'h0D;
      8: o = 6'h0A;
      default: o = 6'($urandom_range(0, 63));
    endcase
    return o;
  endfunction

  initial begin
    int rd_cycles;
    int wr_cycles;
    rst         = 1'b0;
    bus.mem_ack = 1'b1;
    bus.zero    = 1'b0;
    bus.opcode  = 6'h00;

    // Reset held for two cycles with ack high: nothing may be written.
    cyc(0, 1, 0, 6'h00);
    st("reset_state", 0);
    chk("reset_no_wen", 32'({bus.PCWrite, bus.PCWriteCond, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 0);
    cyc(0, 1, 0, 6'h00);
    chk("reset_no_wen2", 32'({bus.PCWrite, bus.PCWriteCond, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 0);
    cyc(1, 1, 0, 6'h00);
    st("if_after_reset", 0);
    chk("if_irwrite", 32'({bus.IRWrite, bus.PCWrite, bus.MemRead}), 32'h7);

    // R-type: 0,1,6,7,0
    cyc(1, 0, 0, 6'h00); st("rtype_id", 1);
    cyc(1, 0, 0, 6'h00); st("rtype_exr", 6);
    chk("rtype_exr_aluop", 32'(bus.ALUOp), 2);
    cyc(1, 0, 0, 6'h00); st("rtype_wbr", 7);
    chk("rtype_wbr_ctrl", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'h4);
    cyc(1, 1, 0, 6'h00); st("rtype_back_if", 0);

    // lw with ack delayed three cycles in MRD (ack on the last legal cycle).
    cyc(1, 0, 0, 6'h23); st("lw_id", 1);
    cyc(1, 0, 0, 6'h23); st("lw_maddr", 2);
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 3), 0, 6'h23);
      if (bus.MemRead && bus.IorD && bus.dbgState == 4'd3) rd_cycles++;
    end
    chk("lw_memread_cycles", 32'(rd_cycles), 4);
    cyc(1, 1, 0, 6'h23); st("lw_wblw", 4);
    chk("lw_wblw_ctrl", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'h7);
    cyc(1, 1, 0, 6'h23); st("lw_back_if", 0);

    // beq taken and not taken.
    cyc(1, 0, 1, 6'h04); st("beq_id", 1);
    cyc(1, 0, 1, 6'h04); st("beq_br", 8);
    chk("beq_ctrl", 32'({bus.PCWriteCond, bus.PCSource, bus.ALUOp}), 32'b1_01_01);
    chk("beq_taken_load", 32'(bus.PCWrite | (bus.PCWriteCond & bus.zero)), 1);
    cyc(1, 1, 0, 6'h04); st("beq_back_if", 0);
    cyc(1, 0, 0, 6'h04);
    cyc(1, 0, 0, 6'h04); st("beq_nt_br", 8);
    chk("beq_not_taken_load", 32'(bus.PCWrite | (bus.PCWriteCond & bus.zero)), 0);
    cyc(1, 1, 0, 6'h04);

    // Illegal opcode: single-cycle pulse.
    cyc(1, 0, 0, 6'h3F); st("ill_id", 1);
    cyc(1, 1, 0, 6'h3F); st("ill_trap", 12);
    chk("ill_pulse_hi", 32'({bus.illegal_op, bus.mem_err}), 32'h2);
    cyc(1, 1, 0, 6'h3F); st("ill_back_if", 0);
    chk("ill_pulse_lo", 32'(bus.illegal_op), 0);

    // addi: traps unless the immediate ALU path is built in.
    cyc(1, 0, 0, 6'h08);
    cyc(1, 0, 0, 6'h08);
    st("addi_dispatch", IMM_EN ? 10 : 12);
    chk("addi_illegal", 32'(bus.illegal_op), IMM_EN ? 0 : 1);
    cyc(1, 1, 0, 6'h08);
    if (IMM_EN) begin
      st("addi_wbi", 11);
      chk("addi_wbi_ctrl", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'h6);
      cyc(1, 1, 0, 6'h08);
    end
    st("addi_back_if", 0);

    // sw with no ack: four wait cycles, then TRAP with mem_err.
    cyc(1, 0, 0, 6'h2B);
    cyc(1, 0, 0, 6'h2B); st("sw_maddr", 2);
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 6'h2B);
      if (bus.MemWrite && bus.dbgState == 4'd5) wr_cycles++;
    end
    chk("sw_wait_cycles", 32'(wr_cycles), 4);
    cyc(1, 0, 0, 6'h2B); st("sw_timeout_trap", 12);
    chk("sw_timeout_err", 32'({bus.mem_err, bus.illegal_op, bus.MemWrite}), 32'h4);
    cyc(1, 1, 0, 6'h2B); st("sw_timeout_if", 0);

    // sw with ack on the 4th wait cycle: ack wins over timeout.
    cyc(1, 0, 0, 6'h2B);
    cyc(1, 0, 0, 6'h2B);
    for (int i = 0; i < 4; i++) cyc(1, (i == 3), 0, 6'h2B);
    cyc(1, 1, 0, 6'h2B); st("sw_late_ack_if", 0);
    chk("sw_late_ack_no_err", 32'(bus.mem_err), 0);

    // Reset during WBR: write suppressed, next state IF.
    cyc(1, 0, 0, 6'h00);
    cyc(1, 0, 0, 6'h00); st("mid_exr", 6);
    cyc(0, 1, 0, 6'h00); st("mid_wbr", 7);
    chk("mid_reset_no_regwrite", 32'(bus.RegWrite), 0);
    cyc(1, 1, 0, 6'h00); st("mid_reset_if", 0);

    // Randomized traffic; opcode only changes as IR loads.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (m_state == 1) bus.opcode = pick_op();
      rst         = ($urandom_range(0, 99) >= 2);
      bus.mem_ack = ($urandom_range(0, 99) < 45);
      bus.zero    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
